// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int REG_ADDR_W_DEF = 5;

   // M-extension divide/remainder selector as carried on ex_func_i
   typedef enum logic [1:0] {
      DIV_F  = 2'b00,
      DIVU_F = 2'b01,
      REM_F  = 2'b10,
      REMU_F = 2'b11
   } div_func_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } div_state_e;

   // Written back when the divider never answers; signed so it extends to any XLEN as all ones
   localparam logic signed [XLEN_DEF-1:0] WDT_RESULT = '1;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// EX-stage / divider / writeback signal bundle for div_issue_ctrl.
// master: the issue controller. slave: the pipeline plus the divider it drives.
interface div_issue_ctrl_if
   import div_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
   logic                  ex_valid_i;
   logic                  ex_is_div_i;
   logic [1:0]            ex_func_i;
   logic [XLEN-1:0]       ex_rs1_i;
   logic [XLEN-1:0]       ex_rs2_i;
   logic [REG_ADDR_W-1:0] ex_rd_i;
   logic                  flush_i;
   logic                  stall_o;
   logic                  div_start_o;
   logic [XLEN-1:0]       div_operand_a_o;
   logic [XLEN-1:0]       div_operand_b_o;
   logic [1:0]            div_func_o;
   logic [XLEN-1:0]       div_result_i;
   logic                  div_done_i;
   logic                  wb_valid_o;
   logic [REG_ADDR_W-1:0] wb_rd_o;
   logic [XLEN-1:0]       wb_data_o;
   logic                  wdt_err_o;

   modport master (
      input  ex_valid_i, ex_is_div_i, ex_func_i, ex_rs1_i, ex_rs2_i, ex_rd_i, flush_i,
      input  div_result_i, div_done_i,
      output stall_o, div_start_o, div_operand_a_o, div_operand_b_o, div_func_o,
      output wb_valid_o, wb_rd_o, wb_data_o, wdt_err_o
   );

   modport slave (
      output ex_valid_i, ex_is_div_i, ex_func_i, ex_rs1_i, ex_rs2_i, ex_rd_i, flush_i,
      output div_result_i, div_done_i,
      input  stall_o, div_start_o, div_operand_a_o, div_operand_b_o, div_func_o,
      input  wb_valid_o, wb_rd_o, wb_data_o, wdt_err_o
   );

endinterface

// File: rtl/div_reuse_cache.sv
// One-entry result cache: remembers the last divide that completed normally so an
// identical back-to-back divide can skip the divider entirely.
module div_reuse_cache #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [XLEN-1:0] lookup_a_i,
   input  logic [XLEN-1:0] lookup_b_i,
   input  logic [1:0]      lookup_func_i,
   output logic            hit_o,
   output logic [XLEN-1:0] hit_res_o,
   input  logic            wr_i,
   input  logic [XLEN-1:0] wr_a_i,
   input  logic [XLEN-1:0] wr_b_i,
   input  logic [1:0]      wr_func_i,
   input  logic [XLEN-1:0] wr_res_i
);

   typedef struct packed {
      logic            vld;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [1:0]      func;
      logic [XLEN-1:0] res;
   } entry_t;

   entry_t ent_q;

   // Overwrite the single entry whenever a fresh result is captured
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ent_q <= '0;
      end else if (wr_i) begin
         ent_q <= '{vld: 1'b1, a: wr_a_i, b: wr_b_i, func: wr_func_i, res: wr_res_i};
      end
   end

   assign hit_o     = ent_q.vld && (ent_q.a == lookup_a_i) && (ent_q.b == lookup_b_i)
                      && (ent_q.func == lookup_func_i);
   assign hit_res_o = ent_q.res;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider.
// Stalls the pipeline while a divide is in flight, holds operands for the divider,
// absorbs flushes by draining the divider, and times out a hung divider.
// Optional build macro DIV_OPERAND_REUSE_EN adds a one-entry result cache that lets an
// identical divide bypass the divider.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int WDT_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   div_issue_ctrl_if.master  bus
);

   localparam int              CNT_W       = $clog2(WDT_CYCLES + 1);
   localparam logic [XLEN-1:0] TIMEOUT_RES = XLEN'(WDT_RESULT);

   div_state_e            state_q, state_d;
   logic [XLEN-1:0]       a_q, b_q, res_q;
   div_func_e             func_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  start_q;
   logic                  wdt_err_q;
   logic [CNT_W-1:0]      wdt_cnt_q;

   logic                  req, in_wait, wdt_exp, wdt_fire, capture;
   logic                  stall, wb_valid;
   logic [XLEN-1:0]       wb_data;
   logic                  hit;
   logic [XLEN-1:0]       hit_res;

   assign req     = bus.ex_valid_i & bus.ex_is_div_i & ~bus.flush_i;
   assign in_wait = (state_q == BUSY) || (state_q == DRAIN);
   // Counter starts at 0 in the first waiting cycle, so this is the last allowed cycle
   assign wdt_exp = in_wait && (wdt_cnt_q == CNT_W'(WDT_CYCLES - 1));
   assign capture = (state_q == BUSY) & bus.div_done_i & ~bus.flush_i;

`ifdef DIV_OPERAND_REUSE_EN
   div_reuse_cache #(.XLEN(XLEN)) u_cache (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .lookup_a_i    (bus.ex_rs1_i),
      .lookup_b_i    (bus.ex_rs2_i),
      .lookup_func_i (bus.ex_func_i),
      .hit_o         (hit),
      .hit_res_o     (hit_res),
      .wr_i          (capture),
      .wr_a_i        (a_q),
      .wr_b_i        (b_q),
      .wr_func_i     (func_q),
      .wr_res_i      (bus.div_result_i)
   );
`else
   assign hit     = 1'b0;
   assign hit_res = '0;
`endif

   // Next state, stall and writeback; flush beats done, done beats the watchdog
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      wb_valid = 1'b0;
      wb_data  = res_q;
      wdt_fire = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall = req;
            if (req) state_d = hit ? RESP : BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (bus.flush_i) begin
               state_d = bus.div_done_i ? IDLE : DRAIN;
            end else if (bus.div_done_i) begin
               state_d = RESP;
            end else if (wdt_exp) begin
               // Retire the op with a poison value rather than hang the pipeline
               state_d  = IDLE;
               stall    = 1'b0;
               wb_valid = 1'b1;
               wb_data  = TIMEOUT_RES;
               wdt_fire = 1'b1;
            end
         end
         RESP: begin
            wb_valid = ~bus.flush_i;
            state_d  = IDLE;
         end
         DRAIN: begin
            // Only a new divide has to wait for the orphaned one to finish
            stall = bus.ex_valid_i & bus.ex_is_div_i;
            if (bus.div_done_i) begin
               state_d = IDLE;
            end else if (wdt_exp) begin
               state_d  = IDLE;
               wdt_fire = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus the one-cycle start pulse on entry to BUSY
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= (state_q == IDLE) && (state_d == BUSY);
      end
   end

   // Operand/destination latches, written only when a divide is accepted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q    <= '0;
         b_q    <= '0;
         func_q <= DIV_F;
         rd_q   <= '0;
      end else if ((state_q == IDLE) && req) begin
         a_q    <= bus.ex_rs1_i;
         b_q    <= bus.ex_rs2_i;
         func_q <= div_func_e'(bus.ex_func_i);
         rd_q   <= bus.ex_rd_i;
      end
   end

   // Result latch: fresh divider result or, on a cache hit, the remembered one
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_q <= '0;
      end else if (capture) begin
         res_q <= bus.div_result_i;
      end else if ((state_q == IDLE) && req && hit) begin
         res_q <= hit_res;
      end
   end

   // Watchdog: restart on entering BUSY/DRAIN, count while waiting; error is sticky
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdt_cnt_q <= '0;
         wdt_err_q <= 1'b0;
      end else begin
         if ((state_d != state_q) && ((state_d == BUSY) || (state_d == DRAIN))) begin
            wdt_cnt_q <= '0;
         end else if (in_wait) begin
            wdt_cnt_q <= wdt_cnt_q + CNT_W'(1);
         end
         if (wdt_fire) wdt_err_q <= 1'b1;
      end
   end

   assign bus.stall_o         = stall;
   assign bus.div_start_o     = start_q;
   assign bus.div_operand_a_o = a_q;
   assign bus.div_operand_b_o = b_q;
   assign bus.div_func_o      = func_q;
   assign bus.wb_valid_o      = wb_valid;
   assign bus.wb_rd_o         = rd_q;
   assign bus.wb_data_o       = wb_data;
   assign bus.wdt_err_o       = wdt_err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: 3-cycle divider model, transaction-level reference
// (arithmetic result, fixed latencies, one-entry cache) and randomized traffic.
module tb_div_issue_ctrl;

   localparam int WDT = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_issue_ctrl_if bus ();

   div_issue_ctrl #(.WDT_CYCLES(WDT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;
   logic hang = 1'b0;
   int dcnt = 0;

   // reference cache contents (last normally completed divide)
   logic       c_vld = 1'b0;
   logic [1:0] c_f;
   logic [31:0] c_a, c_b;

   function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb, r;
      logic ovf;
      sa = a; sb = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (f == 2'b00) begin
         if (b == 0) r = -1; else if (ovf) r = sa; else r = sa / sb;
      end else if (f == 2'b01) begin
         if (b == 0) r = -1; else r = a / b;
      end else if (f == 2'b10) begin
         if (b == 0) r = sa; else if (ovf) r = 0; else r = sa % sb;
      end else begin
         if (b == 0) r = a; else r = a % b;
      end
      return r;
   endfunction

   function automatic logic model_hit(input logic [1:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef DIV_OPERAND_REUSE_EN
      return c_vld && (c_f == f) && (c_a == a) && (c_b == b);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_fill(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      c_vld = 1'b1; c_f = f; c_a = a; c_b = b;
   endtask

   // divider: done two cycles after the start cycle, result from the held operands
   initial begin
      bus.div_done_i   = 1'b0;
      bus.div_result_i = '0;
      forever begin
         @(negedge clk);
         bus.div_done_i   = 1'b0;
         bus.div_result_i = $urandom;
         if (!rst_n) begin
            dcnt = 0;
         end else begin
            if (dcnt > 0) begin
               dcnt--;
               if (dcnt == 0 && !hang) begin
                  bus.div_done_i   = 1'b1;
                  bus.div_result_i = ref_div(bus.div_func_o, bus.div_operand_a_o,
                                             bus.div_operand_b_o);
               end
            end
            if (bus.div_start_o) begin
               total++;
               if (dcnt != 0) begin
                  bad++;
                  $display("FAIL start_overlap got start with %0d cycles pending req 0", dcnt);
               end
               dcnt = 2;
            end
         end
      end
   end

   task automatic drive(input logic v, input logic d, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic fl);
      bus.ex_valid_i = v; bus.ex_is_div_i = d; bus.ex_func_i = f;
      bus.ex_rs1_i = a; bus.ex_rs2_i = b; bus.ex_rd_i = rd; bus.flush_i = fl;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         drive(0, 0, 2'b00, 0, 0, 0, 0);
      end
   endtask

   // hold a divide in EX until the stall drops; record what happened (cycle 0 = presentation)
   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output int st_cyc, output int nst,
                         output int nwb, output logic [31:0] wbd, output logic [4:0] wbr);
      lat = -1; st_cyc = -1; nst = 0; nwb = 0; wbd = '0; wbr = '0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         drive(1, 1, f, a, b, rd, 0);
         #1;
         if (bus.div_start_o) begin nst++; if (st_cyc < 0) st_cyc = i; end
         if (bus.wb_valid_o) begin nwb++; wbd = bus.wb_data_o; wbr = bus.wb_rd_o; end
         if (!bus.stall_o) begin lat = i; break; end
      end
   endtask

   // one op checked against the reference; fills the reference cache on normal completion
   task automatic check_op(input string nm, input logic [1:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
      int lat, sc, ns, nw;
      logic [31:0] d, e;
      logic [4:0] r;
      logic h;
      h = model_hit(f, a, b);
      e = ref_div(f, a, b);
      run_op(f, a, b, rd, lat, sc, ns, nw, d, r);
      total++; if (lat !== (h ? 1 : 4)) begin bad++; $display("FAIL %s_lat got=%0d exp=%0d", nm, lat, h ? 1 : 4); end
      total++; if (ns !== (h ? 0 : 1)) begin bad++; $display("FAIL %s_starts got=%0d exp=%0d", nm, ns, h ? 0 : 1); end
      total++; if (nw !== 1) begin bad++; $display("FAIL %s_wbcount got=%0d exp=1", nm, nw); end
      total++; if (d !== e) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, d, e); end
      total++; if (r !== rd) begin bad++; $display("FAIL %s_rd got=%0d exp=%0d", nm, r, rd); end
      if (!h) begin
         total++; if (sc !== 1) begin bad++; $display("FAIL %s_startcyc got=%0d exp=1", nm, sc); end
      end
      model_fill(f, a, b);
   endtask

   task automatic test_reset;
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      rst_n = 1'b0;
      c_vld = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if ({bus.stall_o, bus.div_start_o, bus.wb_valid_o, bus.wdt_err_o} !== 4'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0000",
                         {bus.stall_o, bus.div_start_o, bus.wb_valid_o, bus.wdt_err_o}); end
      total++; if ({bus.div_operand_a_o, bus.div_operand_b_o, bus.div_func_o} !== '0) begin
         bad++; $display("FAIL reset_operands got a=%h b=%h f=%0d exp 0", bus.div_operand_a_o,
                         bus.div_operand_b_o, bus.div_func_o); end
      total++; if ({bus.wb_data_o, bus.wb_rd_o} !== '0) begin
         bad++; $display("FAIL reset_wb got data=%h rd=%0d exp 0", bus.wb_data_o, bus.wb_rd_o); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int lat, sc, ns, nw;
      logic [31:0] d;
      logic [4:0] r;
      run_op(2'b00, 32'hFFFF_FFEF, 32'd5, 5'd3, lat, sc, ns, nw, d, r);
      total++; if (lat !== 4) begin bad++; $display("FAIL basic_lat got=%0d exp=4", lat); end
      total++; if (sc !== 1) begin bad++; $display("FAIL basic_startcyc got=%0d exp=1", sc); end
      total++; if (ns !== 1) begin bad++; $display("FAIL basic_starts got=%0d exp=1", ns); end
      total++; if (nw !== 1) begin bad++; $display("FAIL basic_wbcount got=%0d exp=1", nw); end
      total++; if (d !== 32'hFFFF_FFFD) begin bad++; $display("FAIL basic_data got=%h exp=fffffffd", d); end
      total++; if (r !== 5'd3) begin bad++; $display("FAIL basic_rd got=%0d exp=3", r); end
      model_fill(2'b00, 32'hFFFF_FFEF, 32'd5);
      idle(1);
   endtask

   task automatic test_funcs;
      logic [1:0]  tf [7] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
      logic [31:0] ta [7] = '{32'hFFFF_FFEF, 32'hFFFF_FFEF, 32'hFFFF_FFEF, 32'd7, 32'd7,
                              32'h8000_0000, 32'h8000_0000};
      logic [31:0] tb [7] = '{32'd5, 32'd5, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] te [7] = '{32'h3333_332F, 32'h0000_0004, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'h0000_0007, 32'h8000_0000, 32'h0000_0000};
      int lat, sc, ns, nw;
      logic [31:0] d;
      logic [4:0] r;
      for (int i = 0; i < 7; i++) begin
         run_op(tf[i], ta[i], tb[i], 5'(i + 1), lat, sc, ns, nw, d, r);
         total++; if (d !== te[i]) begin bad++; $display("FAIL funcs_data[%0d] got=%h exp=%h", i, d, te[i]); end
         total++; if (lat !== 4) begin bad++; $display("FAIL funcs_lat[%0d] got=%0d exp=4", i, lat); end
         model_fill(tf[i], ta[i], tb[i]);
         idle(1);
      end
   endtask

   task automatic test_flush_drain;
      int lat, sc, ns, nw;
      logic [31:0] d;
      logic [4:0] r;
      @(negedge clk); drive(1, 1, 2'b00, 32'h1234, 32'h56, 5'd4, 0); #1;
      total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL drain_req_stall got=%b exp=1", bus.stall_o); end
      @(negedge clk); #1;
      total++; if (bus.div_start_o !== 1'b1) begin bad++; $display("FAIL drain_start got=%b exp=1", bus.div_start_o); end
      @(negedge clk); drive(0, 0, 2'b00, 0, 0, 0, 1); #1;
      total++; if ({bus.stall_o, bus.wb_valid_o} !== 2'b10) begin
         bad++; $display("FAIL drain_flush got stall,wb=%b exp=10", {bus.stall_o, bus.wb_valid_o}); end
      run_op(2'b01, 32'd10, 32'd3, 5'd7, lat, sc, ns, nw, d, r);
      total++; if (lat !== 5) begin bad++; $display("FAIL drain_next_lat got=%0d exp=5", lat); end
      total++; if (sc !== 2) begin bad++; $display("FAIL drain_next_startcyc got=%0d exp=2", sc); end
      total++; if (nw !== 1) begin bad++; $display("FAIL drain_next_wbcount got=%0d exp=1", nw); end
      total++; if (d !== 32'd3) begin bad++; $display("FAIL drain_next_data got=%h exp=00000003", d); end
      model_fill(2'b01, 32'd10, 32'd3);
      idle(1);
   endtask

   task automatic test_flush_done;
      repeat (3) begin @(negedge clk); drive(1, 1, 2'b00, 32'd100, 32'd7, 5'd5, 0); end
      @(negedge clk); drive(0, 0, 2'b00, 0, 0, 0, 1); #1;
      total++; if ({bus.stall_o, bus.wb_valid_o} !== 2'b10) begin
         bad++; $display("FAIL fldone_cycle got stall,wb=%b exp=10", {bus.stall_o, bus.wb_valid_o}); end
      @(negedge clk); drive(0, 0, 2'b00, 0, 0, 0, 0); #1;
      total++; if ({bus.stall_o, bus.wb_valid_o} !== 2'b00) begin
         bad++; $display("FAIL fldone_after got stall,wb=%b exp=00", {bus.stall_o, bus.wb_valid_o}); end
      check_op("fldone_retry", 2'b00, 32'd100, 32'd7, 5'd5);
      idle(1);
   endtask

   task automatic test_resp_flush;
      repeat (4) begin @(negedge clk); drive(1, 1, 2'b01, 32'd1000, 32'd9, 5'd6, 0); end
      @(negedge clk); drive(1, 1, 2'b01, 32'd1000, 32'd9, 5'd6, 1); #1;
      total++; if ({bus.stall_o, bus.wb_valid_o} !== 2'b00) begin
         bad++; $display("FAIL respflush got stall,wb=%b exp=00", {bus.stall_o, bus.wb_valid_o}); end
      model_fill(2'b01, 32'd1000, 32'd9);
      check_op("respflush_again", 2'b01, 32'd1000, 32'd9, 5'd6);
      idle(1);
   endtask

   task automatic test_back_to_back;
      check_op("b2b_first", 2'b00, 32'hFFFF_FFEF, 32'd5, 5'd9);
      check_op("b2b_second", 2'b00, 32'hFFFF_FFEF, 32'd5, 5'd10);
      idle(1);
   endtask

   task automatic test_random;
      logic [1:0] f;
      logic [31:0] a, b;
      f = 2'b00; a = '0; b = '0;
      for (int k = 0; k < 40; k++) begin
         if (k == 0 || $urandom_range(2) != 0) begin
            f = 2'($urandom_range(3));
            a = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(4))
               0:       b = 32'd0;
               1:       b = 32'hFFFF_FFFF;
               2:       b = 32'($urandom_range(15));
               default: b = $urandom;
            endcase
         end
         check_op("rand", f, a, b, 5'($urandom_range(31)));
         idle($urandom_range(2));
      end
   endtask

   task automatic test_watchdog;
      int lat, sc, ns, nw;
      logic [31:0] d;
      logic [4:0] r;
      @(negedge clk); #1;
      total++; if (bus.wdt_err_o !== 1'b0) begin bad++; $display("FAIL wdt_pre got=%b exp=0", bus.wdt_err_o); end
      hang = 1'b1;
      run_op(2'b01, 32'h0BAD_F00D, 32'h7FFF_FFF1, 5'd12, lat, sc, ns, nw, d, r);
      total++; if (lat !== WDT) begin bad++; $display("FAIL wdt_lat got=%0d exp=%0d", lat, WDT); end
      total++; if (nw !== 1) begin bad++; $display("FAIL wdt_wbcount got=%0d exp=1", nw); end
      total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wdt_data got=%h exp=ffffffff", d); end
      total++; if (r !== 5'd12) begin bad++; $display("FAIL wdt_rd got=%0d exp=12", r); end
      @(negedge clk); drive(0, 0, 2'b00, 0, 0, 0, 0); #1;
      total++; if ({bus.wdt_err_o, bus.stall_o} !== 2'b10) begin
         bad++; $display("FAIL wdt_err got err,stall=%b exp=10", {bus.wdt_err_o, bus.stall_o}); end
      hang = 1'b0;
      check_op("wdt_after", 2'b01, 32'h0BAD_F00D, 32'h7FFF_FFF1, 5'd13);
      #1;
      total++; if (bus.wdt_err_o !== 1'b1) begin bad++; $display("FAIL wdt_sticky got=%b exp=1", bus.wdt_err_o); end
      idle(1);
      rst_n = 1'b0;
      #1;
      total++; if (bus.wdt_err_o !== 1'b0) begin bad++; $display("FAIL wdt_reset got=%b exp=0", bus.wdt_err_o); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_funcs();
      test_flush_drain();
      test_flush_done();
      test_resp_flush();
      test_back_to_back();
      test_random();
      test_watchdog();
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
